// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store buffer with youngest-match load forwarding
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wd,
    output logic [31:0] cpu_rd,
    output logic        stall,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic        empty,
    output logic        full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [29:0]   addr_q [DEPTH];
    logic [29:0]   addr_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;

    logic        drain;
    logic        push;
    logic        hit;
    logic [31:0] fwd_data;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = ^cpu_addr[1:0];

    // Status, memory port steering and stall; draining always wins the port once full.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        drain    = !empty && (!cpu_re || full);
        push     = cpu_we && !full;
        stall    = full && (cpu_we || cpu_re);
        mem_we   = drain;
        mem_addr = drain ? {addr_q[head_q], 2'b00} : cpu_addr;
        mem_wd   = drain ? data_q[head_q] : 32'h0;
    end

    // Walk entries oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        hit      = 1'b0;
        fwd_data = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((PW+1)'(i) < count_q) && (addr_q[head_q + PW'(i)] == cpu_addr[31:2])) begin
                hit      = 1'b1;
                fwd_data = data_q[head_q + PW'(i)];
            end
        end
        if (cpu_re && !stall) begin
            cpu_rd = hit ? fwd_data : mem_rd;
        end else begin
            cpu_rd = 32'h0;
        end
    end

    // Next-state: write at tail on push, retire head on drain, count tracks the difference.
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            addr_d[tail_q] = cpu_addr[31:2];
            data_d[tail_q] = cpu_wd;
            tail_d         = tail_q + 1'b1;
        end
        if (drain) begin
            head_d = head_q + 1'b1;
        end
        count_d = count_q + (PW+1)'(push) - (PW+1)'(drain);
    end

    // Pointer and occupancy state; reset discards every pending store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payloads carry no reset; only slots below count are ever read.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic [31:0] cpu_addr = 32'h44;
    logic [31:0] cpu_wd = 32'h0;
    logic [31:0] cpu_rd;
    logic        stall;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        empty;
    logic        full;

    logic [31:0] ram  [64];
    logic [31:0] mmem [64];

    typedef struct packed {
        logic [29:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] wlog[$];
    int          n_cmp = 0;
    int          n_err = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_we   (cpu_we),
        .cpu_re   (cpu_re),
        .cpu_addr (cpu_addr),
        .cpu_wd   (cpu_wd),
        .cpu_rd   (cpu_rd),
        .stall    (stall),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd),
        .empty    (empty),
        .full     (full)
    );

    always #5 clk = ~clk;

    assign mem_rd = ram[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr[7:2]] <= mem_wd;
            wlog.push_back(mem_addr);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_edge();
        int sz;
        bit dr;
        sz = mq.size();
        dr = (sz != 0) && (!cpu_re || sz == DEPTH);
        if (dr) begin
            mmem[mq[0].a[5:0]] = mq[0].d;
            void'(mq.pop_front());
        end
        if (cpu_we && sz != DEPTH) begin
            mq.push_back({cpu_addr[31:2], cpu_wd});
        end
    endtask

    task automatic compare_all();
        int          sz;
        bit          e_full, e_drain, e_stall;
        logic [31:0] e_addr, e_wd, e_rd;
        sz      = mq.size();
        e_full  = (sz == DEPTH);
        e_drain = (sz != 0) && (!cpu_re || e_full);
        e_stall = e_full && (cpu_we || cpu_re);
        e_addr  = e_drain ? {mq[0].a, 2'b00} : cpu_addr;
        e_wd    = e_drain ? mq[0].d : 32'h0;
        e_rd    = 32'h0;
        if (cpu_re && !e_stall) begin
            e_rd = mmem[cpu_addr[7:2]];
            foreach (mq[i]) begin
                if (mq[i].a == cpu_addr[31:2]) e_rd = mq[i].d;
            end
        end
        chk("m_empty",    {31'h0, empty},  {31'h0, sz == 0});
        chk("m_full",     {31'h0, full},   {31'h0, e_full});
        chk("m_stall",    {31'h0, stall},  {31'h0, e_stall});
        chk("m_mem_we",   {31'h0, mem_we}, {31'h0, e_drain});
        chk("m_mem_addr", mem_addr, e_addr);
        chk("m_mem_wd",   mem_wd, e_wd);
        chk("m_cpu_rd",   cpu_rd, e_rd);
    endtask

    // Reference model advances on the same edges as the design.
    always @(posedge clk or negedge reset) begin
        if (!reset) mq.delete();
        else        model_edge();
    end

    // Every cycle, outputs are checked against the model mid-cycle.
    always @(negedge clk) begin
        #1;
        compare_all();
    end

    task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        cpu_we   = we;
        cpu_re   = re;
        cpu_addr = a;
        cpu_wd   = d;
    endtask

    task automatic mid();
        @(negedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i]  = 32'hC0DE_0000 + i;
            mmem[i] = 32'hC0DE_0000 + i;
        end
        #1;
        chk("rst_empty",    {31'h0, empty},  32'h1);
        chk("rst_full",     {31'h0, full},   32'h0);
        chk("rst_stall",    {31'h0, stall},  32'h0);
        chk("rst_mem_we",   {31'h0, mem_we}, 32'h0);
        chk("rst_mem_wd",   mem_wd,   32'h0);
        chk("rst_mem_addr", mem_addr, 32'h44);
        chk("rst_cpu_rd",   cpu_rd,   32'h0);
        @(negedge clk);
        #2 reset = 1'b1;

        // single store drains on the next cycle
        drive(1, 0, 32'h20, 32'hAAAA5555);
        drive(0, 0, 32'h20, 32'h0);
        mid();
        chk("st_mem_we",   {31'h0, mem_we}, 32'h1);
        chk("st_mem_addr", mem_addr, 32'h20);
        chk("st_mem_wd",   mem_wd,   32'hAAAA5555);
        drive(0, 0, 32'h0, 32'h0);
        mid();
        chk("st_empty", {31'h0, empty}, 32'h1);
        chk("st_ram8",  ram[8], 32'hAAAA5555);

        // forwarding under continuous loads
        drive(1, 1, 32'h10, 32'h1);
        mid();
        chk("fw_same_cycle", cpu_rd, 32'hC0DE0004);
        drive(1, 1, 32'h10, 32'h2);
        mid();
        chk("fw_first", cpu_rd, 32'h1);
        drive(0, 1, 32'h10, 32'h0);
        mid();
        chk("fw_youngest", cpu_rd, 32'h2);
        chk("fw_no_we",    {31'h0, mem_we}, 32'h0);
        drive(0, 1, 32'h14, 32'h0);
        mid();
        chk("fw_miss", cpu_rd, 32'hC0DE0005);
        drive(0, 1, 32'h40, 32'h0);
        mid();
        chk("fw_starve", {31'h0, mem_we}, 32'h0);
        drive(0, 0, 32'h0, 32'h0);
        drive(0, 0, 32'h0, 32'h0);
        drive(0, 0, 32'h0, 32'h0);
        mid();
        chk("fw_ram4", ram[4], 32'h2);

        // fill, one-cycle stall, retry and drain order
        wlog.delete();
        drive(1, 1, 32'h0, 32'h100);
        drive(1, 1, 32'h4, 32'h101);
        drive(1, 1, 32'h8, 32'h102);
        drive(1, 1, 32'hC, 32'h103);
        drive(1, 1, 32'h10, 32'h5);
        mid();
        chk("fl_full",     {31'h0, full},   32'h1);
        chk("fl_stall",    {31'h0, stall},  32'h1);
        chk("fl_mem_we",   {31'h0, mem_we}, 32'h1);
        chk("fl_mem_addr", mem_addr, 32'h0);
        chk("fl_cpu_rd",   cpu_rd,   32'h0);
        drive(1, 1, 32'h10, 32'h5);
        mid();
        chk("fl_retry_stall", {31'h0, stall}, 32'h0);
        for (int k = 0; k < 6; k++) drive(0, 0, 32'h0, 32'h0);
        mid();
        chk("fl_log_n", wlog.size(), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < wlog.size()) chk("fl_order", wlog[k], 32'(4 * k));
        end
        chk("fl_ram4", ram[4], 32'h5);

        // simultaneous push and drain, pointers wrapping
        drive(1, 1, 32'h80, 32'h200);
        drive(1, 1, 32'h84, 32'h201);
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 32'h80 + 32'(4 * (k % 8)), 32'h300 + 32'(k));
            mid();
            chk("pp_mem_we", {31'h0, mem_we}, 32'h1);
            chk("pp_empty",  {31'h0, empty},  32'h0);
            chk("pp_full",   {31'h0, full},   32'h0);
        end
        drive(0, 0, 32'h0, 32'h0);
        mid();
        chk("pp_tail1", {31'h0, mem_we}, 32'h1);
        drive(0, 0, 32'h0, 32'h0);
        mid();
        chk("pp_tail2", {31'h0, mem_we}, 32'h1);
        drive(0, 0, 32'h0, 32'h0);
        mid();
        chk("pp_done",  {31'h0, mem_we}, 32'h0);
        chk("pp_ram32", ram[32], 32'h308);
        chk("pp_ram33", ram[33], 32'h309);

        // load miss with three pending stores
        drive(1, 1, 32'h60, 32'h1);
        drive(1, 1, 32'h64, 32'h2);
        drive(1, 1, 32'h68, 32'h3);
        drive(0, 1, 32'h70, 32'h0);
        mid();
        chk("ms_cpu_rd",   cpu_rd,   32'hC0DE001C);
        chk("ms_mem_addr", mem_addr, 32'h70);
        chk("ms_mem_we",   {31'h0, mem_we}, 32'h0);
        chk("ms_empty",    {31'h0, empty},  32'h0);
        for (int k = 0; k < 4; k++) drive(0, 0, 32'h0, 32'h0);

        // reset in the middle of a drain discards the store
        drive(1, 0, 32'h30, 32'h99);
        drive(0, 0, 32'h30, 32'h0);
        mid();
        chk("rd_pre_we", {31'h0, mem_we}, 32'h1);
        reset = 1'b0;
        #1;
        chk("rd_empty",  {31'h0, empty},  32'h1);
        chk("rd_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rd_stall",  {31'h0, stall},  32'h0);
        chk("rd_mem_wd", mem_wd, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #3 reset = 1'b1;
        drive(0, 0, 32'h0, 32'h0);
        mid();
        chk("rd_ram12", ram[12], 32'hC0DE000C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
